// File: rtl/if_stage_if.sv
// Fetch-stage bus: control inputs, instruction memory port and IF/ID outputs.
// The master modport is the surrounding pipeline; the slave is the fetch stage.
interface if_stage_if;
    logic        start_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] target_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic [31:0] fetch_cnt_o;
    logic        running_o;

    modport master (
        output start_i, stall_i, redirect_i, target_i, instr_i,
        input  pc_o, pc_plus4_o, ifid_pc4_o, ifid_instr_o,
        input  ifid_valid_o, fetch_cnt_o, running_o
    );

    modport slave (
        input  start_i, stall_i, redirect_i, target_i, instr_i,
        output pc_o, pc_plus4_o, ifid_pc4_o, ifid_instr_o,
        output ifid_valid_o, fetch_cnt_o, running_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem address and IF/ID register.
// Stall beats redirect beats sequential fetch; reset beats everything.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_stage_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    ifid_t       ifid_q, ifid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ifid_d  = ifid_q;
        unique case (state_q)
            IDLE: begin
                pc_d   = RESET_PC;
                ifid_d = BUBBLE;
                if (bus.start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.stall_i) begin
                    pc_d = pc_q;
                end else if (bus.redirect_i) begin
                    // Wrong-path instruction in IF is squashed.
                    pc_d   = bus.target_i & 32'hFFFF_FFFC;
                    ifid_d = BUBBLE;
                end else begin
                    pc_d   = pc_plus4;
                    ifid_d = '{pc4: pc_plus4, instr: bus.instr_i, valid: 1'b1};
                    cnt_d  = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'h0;
            ifid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ifid_q  <= ifid_d;
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.pc_plus4_o   = pc_plus4;
    assign bus.ifid_pc4_o   = ifid_q.pc4;
    assign bus.ifid_instr_o = ifid_q.instr;
    assign bus.ifid_valid_o = ifid_q.valid;
    assign bus.fetch_cnt_o  = cnt_q;
    assign bus.running_o    = (state_q == RUN);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the corner sequences,
// then random control traffic against an abstract fetch model.
module tb_if_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h2008_0005 ^ a;
    endfunction

    always_comb bus.instr_i = imem(bus.pc_o);

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        rst;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        run;
    } vec_t;

    vec_t vt[19];

    // Abstract model state
    logic [31:0] m_pc, m_cnt, m_pc4, m_instr;
    logic        m_valid, m_run;

    task automatic model_reset();
        m_pc = 32'h0; m_cnt = 32'h0; m_pc4 = 32'h0;
        m_instr = 32'h0; m_valid = 1'b0; m_run = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic st, input logic sl,
                              input logic rd, input logic [31:0] tg);
        if (r) begin
            model_reset();
        end else if (!m_run) begin
            m_run = st;
        end else if (sl) begin
            m_run = 1'b1;
        end else if (rd) begin
            m_pc = {tg[31:2], 2'b00};
            m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = imem(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    initial begin
        //        st sl rd target         rs  pc            v  instr          pc4           cnt run
        vt[0]  = '{1,0,0,32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0, 1};
        vt[1]  = '{0,0,0,32'h0,          0, 32'h4,        1, 32'h2008_0005,32'h4,        1, 1};
        vt[2]  = '{0,0,0,32'h0,          0, 32'h8,        1, 32'h2008_0001,32'h8,        2, 1};
        vt[3]  = '{0,0,1,32'h43,         0, 32'h40,       0, 32'h0,        32'h0,        2, 1};
        vt[4]  = '{0,0,0,32'h0,          0, 32'h44,       1, 32'h2008_0045,32'h44,       3, 1};
        vt[5]  = '{0,0,0,32'h0,          0, 32'h48,       1, 32'h2008_0041,32'h48,       4, 1};
        vt[6]  = '{0,0,1,32'h10,         0, 32'h10,       0, 32'h0,        32'h0,        4, 1};
        vt[7]  = '{0,1,0,32'h0,          0, 32'h10,       0, 32'h0,        32'h0,        4, 1};
        vt[8]  = '{0,1,0,32'h0,          0, 32'h10,       0, 32'h0,        32'h0,        4, 1};
        vt[9]  = '{0,1,0,32'h0,          0, 32'h10,       0, 32'h0,        32'h0,        4, 1};
        vt[10] = '{1,0,0,32'h0,          0, 32'h14,       1, 32'h2008_0015,32'h14,       5, 1};
        vt[11] = '{0,1,1,32'h100,        0, 32'h14,       1, 32'h2008_0015,32'h14,       5, 1};
        vt[12] = '{0,0,1,32'h100,        0, 32'h100,      0, 32'h0,        32'h0,        5, 1};
        vt[13] = '{0,0,0,32'h0,          0, 32'h104,      1, 32'h2008_0105,32'h104,      6, 1};
        vt[14] = '{0,0,1,32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,0, 32'h0,        32'h0,        6, 1};
        vt[15] = '{0,0,0,32'h0,          0, 32'h0,        1, 32'hDFF7_FFF9,32'h0,        7, 1};
        vt[16] = '{0,0,1,32'h200,        0, 32'h200,      0, 32'h0,        32'h0,        7, 1};
        vt[17] = '{0,1,1,32'h44,         1, 32'h0,        0, 32'h0,        32'h0,        0, 0};
        vt[18] = '{0,0,0,32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0, 0};

        bus.start_i = 0; bus.stall_i = 0; bus.redirect_i = 0;
        bus.target_i = 32'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;

        chk("rst_pc",    bus.pc_o,         32'h0);
        chk("rst_pc4c",  bus.pc_plus4_o,   32'h4);
        chk("rst_ipc4",  bus.ifid_pc4_o,   32'h0);
        chk("rst_instr", bus.ifid_instr_o, 32'h0);
        chk("rst_valid", {31'h0, bus.ifid_valid_o}, 32'h0);
        chk("rst_cnt",   bus.fetch_cnt_o,  32'h0);
        chk("rst_run",   {31'h0, bus.running_o},    32'h0);

        for (int i = 0; i < 19; i++) begin
            bus.start_i    = vt[i].start;
            bus.stall_i    = vt[i].stall;
            bus.redirect_i = vt[i].redir;
            bus.target_i   = vt[i].target;
            rst            = vt[i].rst;
            step();
            chk($sformatf("v%0d_pc", i),    bus.pc_o,         vt[i].pc);
            chk($sformatf("v%0d_pc4c", i),  bus.pc_plus4_o,   vt[i].pc + 32'd4);
            chk($sformatf("v%0d_valid", i), {31'h0, bus.ifid_valid_o},
                {31'h0, vt[i].valid});
            chk($sformatf("v%0d_instr", i), bus.ifid_instr_o, vt[i].instr);
            chk($sformatf("v%0d_ipc4", i),  bus.ifid_pc4_o,   vt[i].pc4);
            chk($sformatf("v%0d_cnt", i),   bus.fetch_cnt_o,  vt[i].cnt);
            chk($sformatf("v%0d_run", i),   {31'h0, bus.running_o},
                {31'h0, vt[i].run});
        end
        rst = 1'b0;

        // Random traffic against the abstract model
        bus.start_i = 0; bus.stall_i = 0; bus.redirect_i = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic r, st, sl, rd;
            logic [31:0] tg;
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 15);
            sl = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 20);
            tg = $urandom;
            bus.start_i = st; bus.stall_i = sl;
            bus.redirect_i = rd; bus.target_i = tg;
            rst = r;
            model_edge(r, st, sl, rd, tg);
            step();
            chk("r_pc",    bus.pc_o,         m_pc);
            chk("r_pc4c",  bus.pc_plus4_o,   m_pc + 32'd4);
            chk("r_instr", bus.ifid_instr_o, m_instr);
            chk("r_ipc4",  bus.ifid_pc4_o,   m_pc4);
            chk("r_valid", {31'h0, bus.ifid_valid_o}, {31'h0, m_valid});
            chk("r_cnt",   bus.fetch_cnt_o,  m_cnt);
            chk("r_run",   {31'h0, bus.running_o},    {31'h0, m_run});
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core: holds the program counter, drives the instruction-memory address, and registers each fetched instruction with its PC+4 into the IF/ID pipeline register. It sits directly downstream of the jump-target mux, which builds `{PC+4[31:28], instr[25:0]<<2}` and feeds the fetch stage's redirect target. It also supplies the `pc_plus4_o` value that mux uses as its upper-bit source and fall-through input.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `NOP_INSTR`, default `32'h0000_0000`: instruction word inserted as a bubble.

- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset; one clock, synchronous, active-high.
- `start_i`, input, 1: begins fetching; sampled only in IDLE.
- `stall_i`, input, 1: hazard-unit stall; freezes PC and IF/ID.
- `redirect_i`, input, 1: taken jump or branch resolved in ID.
- `target_i`, input, 32: redirect target from the jump/branch mux.
- `instr_i`, input, 32: instruction memory read data for `pc_o`, combinational, same cycle.
- `pc_o`, output, 32: current PC and instruction memory address.
- `pc_plus4_o`, output, 32: combinational `pc_o + 4`.
- `ifid_pc4_o`, output, 32: registered PC+4 of the instruction in ID.
- `ifid_instr_o`, output, 32: registered instruction in ID.
- `ifid_valid_o`, output, 1: high when `ifid_instr_o` is a real fetched instruction.
- `fetch_cnt_o`, output, 32: count of instructions accepted into IF/ID.
- `running_o`, output, 1: high in RUN.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
- IDLE → RUN when `start_i`=1 at a clock edge.
- RUN has no exit except `rst_i`.
- `start_i` is ignored in RUN.
- IDLE behaviour:
  - PC holds `RESET_PC`.
  - IF/ID holds a bubble.
  - Counter holds its value.
- RUN priority, evaluated at each edge:
  1. `rst_i`: highest priority.
  2. `stall_i`: PC, IF/ID and counter hold. `redirect_i` is ignored while stalled; the instruction in ID re-asserts it after the stall releases.
  3. `redirect_i`:
     - PC ← `{target_i[31:2], 2'b00}`.
     - IF/ID ← bubble (`ifid_instr_o`=`NOP_INSTR`, `ifid_pc4_o`=0, `ifid_valid_o`=0). The wrong-path instruction is squashed.
     - Counter does not increment.
  4. Otherwise:
     - PC ← `pc_o + 4`.
     - IF/ID ← {`pc_plus4_o`, `instr_i`, valid=1}.
     - `fetch_cnt_o` += 1.
- The transition edge IDLE→RUN only changes state; the first fetch is captured on the following edge.
- Arithmetic:
  - PC+4 is a 32-bit add; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - `fetch_cnt_o` wraps from 32'hFFFF_FFFF to 0.
  - `pc_o[1:0]` is always 2'b00.

## Timing
- Reset values:
  - State = IDLE.
  - `pc_o`=`RESET_PC`, `pc_plus4_o`=`RESET_PC`+4.
  - `ifid_pc4_o`=0, `ifid_instr_o`=`NOP_INSTR`, `ifid_valid_o`=0.
  - `fetch_cnt_o`=0, `running_o`=0.
- Reset applied mid-RUN overrides stall and redirect on the same edge.
- Fetch latency:
  - `instr_i` for PC=P appears on `ifid_instr_o` one edge after `pc_o`=P.
- Redirect latency:
  - Asserted in cycle N, `pc_o`=target in cycle N+1.
  - Target instruction appears in IF/ID in cycle N+2.
  - Cycle N+1 IF/ID is a bubble: one-cycle penalty.
- Stall held for K cycles gives K cycles of identical `pc_o`/IF/ID outputs.
- `pc_plus4_o` and `pc_o` are stable for the entire cycle, so the upstream mux and instruction memory may use them combinationally.

## Test plan
- Reset then `start_i`=1 for one cycle, `instr_i`=32'h2008_0005 at PC 0:
  - `pc_o` runs 0, 0, 4, 8.
  - After the 3rd edge, `ifid_instr_o`=32'h2008_0005, `ifid_pc4_o`=4, valid=1, `fetch_cnt_o`=1.
- Redirect at PC=8 with `target_i`=32'h0000_0043:
  - Next `pc_o`=32'h0000_0040.
  - IF/ID bubble (valid=0, instr=0), counter unchanged.
  - Following edge captures the instruction at 0x40 with `ifid_pc4_o`=0x44.
- `stall_i`=1 for 3 cycles at PC=0x10:
  - `pc_o`, IF/ID and `fetch_cnt_o` frozen for 3 cycles.
  - Normal fetch resumes with `pc_o`=0x14.
- `stall_i`=1 and `redirect_i`=1 together (target 0x100):
  - Stall wins; PC holds.
  - Releasing the stall with `redirect_i` still high sends `pc_o` to 0x100 on the next edge.
- `rst_i`=1 mid-RUN at PC=0x200 with `redirect_i`=1:
  - Next edge gives `pc_o`=`RESET_PC`, state IDLE, `fetch_cnt_o`=0, valid=0.
  - `start_i` low keeps PC at `RESET_PC`.
- PC wrap:
  - Redirect to 32'hFFFF_FFFC, then one normal fetch.
  - `pc_o`=0, `ifid_pc4_o`=0.
